// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU operation codes, forwarding selects,
// and default datapath widths.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_NOP = 4'h0,
    ALU_OR  = 4'h3,
    ALU_ADD = 4'h4,
    ALU_SUB = 4'h5,
    ALU_AND = 4'h7
  } alu_op_e;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage

// File: rtl/ex_alu_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, grouped as one bundle.
interface ex_alu_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic [3:0]        operation;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm;
  logic              alu_src;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [DATA_W-1:0] exmem_fwd;
  logic [DATA_W-1:0] memwb_fwd;
  logic [REG_AW-1:0] dest_reg;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              stall;
  logic              flush;

  logic              out_valid;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [REG_AW-1:0] out_dest_reg;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              zero;
  logic              overflow;
  logic              illegal_op;

  modport master (
    output in_valid, operation, rs_data, rt_data, imm, alu_src, fwd_a, fwd_b,
           exmem_fwd, memwb_fwd, dest_reg, reg_write, mem_read, mem_write,
           stall, flush,
    input  out_valid, alu_result, store_data, out_dest_reg, out_reg_write,
           out_mem_read, out_mem_write, zero, overflow, illegal_op
  );

  modport slave (
    input  in_valid, operation, rs_data, rt_data, imm, alu_src, fwd_a, fwd_b,
           exmem_fwd, memwb_fwd, dest_reg, reg_write, mem_read, mem_write,
           stall, flush,
    output out_valid, alu_result, store_data, out_dest_reg, out_reg_write,
           out_mem_read, out_mem_write, zero, overflow, illegal_op
  );
endinterface

// File: rtl/ex_alu_stage_alu_core.sv
// Combinational ALU: result, signed add/sub overflow, and undefined-code flag.
module alu_core
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_operation,
  output logic [DATA_W-1:0] o_result,
  output logic              o_overflow,
  output logic              o_illegal
);

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_sa;
  logic              w_sb;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_sa   = i_a[DATA_W-1];
  assign w_sb   = i_b[DATA_W-1];

  always_comb begin
    o_result   = '0;
    o_overflow = 1'b0;
    o_illegal  = 1'b0;
    case (i_operation)
      ALU_NOP: o_result = '0;
      ALU_OR:  o_result = i_a | i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_ADD: begin
        o_result   = w_sum;
        o_overflow = (w_sa == w_sb) && (w_sum[DATA_W-1] != w_sa);
      end
      ALU_SUB: begin
        o_result   = w_diff;
        o_overflow = (w_sa != w_sb) && (w_diff[DATA_W-1] != w_sa);
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_alu_stage.sv
// MIPS execute stage: operand forwarding, ALU, and the EX/MEM pipeline register
// with flush > stall > load update priority.
module ex_alu_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_alu_stage_if.slave bus
);

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_bf;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_result;
  logic              w_overflow;
  logic              w_illegal;

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_store;
  logic [REG_AW-1:0] r_dest;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_zero;
  logic              r_overflow;
  logic              r_illegal;

  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] reg_val,
    input logic [DATA_W-1:0] exmem_val,
    input logic [DATA_W-1:0] memwb_val
  );
    case (sel)
      FWD_EXMEM: fwd_mux = exmem_val;
      FWD_MEMWB: fwd_mux = memwb_val;
      default:   fwd_mux = reg_val;
    endcase
  endfunction

  assign w_a  = fwd_mux(bus.fwd_a, bus.rs_data, bus.exmem_fwd, bus.memwb_fwd);
  assign w_bf = fwd_mux(bus.fwd_b, bus.rt_data, bus.exmem_fwd, bus.memwb_fwd);
  assign w_b  = bus.alu_src ? bus.imm : w_bf;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .i_a         (w_a),
    .i_b         (w_b),
    .i_operation (bus.operation),
    .o_result    (w_result),
    .o_overflow  (w_overflow),
    .o_illegal   (w_illegal)
  );

  // Flush clears only the control set; datapath fields keep their old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_store     <= '0;
      r_dest      <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (bus.flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_overflow  <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (!bus.stall) begin
      r_valid     <= bus.in_valid;
      r_result    <= w_result;
      r_store     <= w_bf;
      r_dest      <= bus.dest_reg;
      r_zero      <= (w_result == '0);
      r_reg_write <= bus.in_valid & bus.reg_write;
      r_mem_read  <= bus.in_valid & bus.mem_read;
      r_mem_write <= bus.in_valid & bus.mem_write;
      r_overflow  <= bus.in_valid & w_overflow;
      r_illegal   <= bus.in_valid & w_illegal;
    end
  end

  assign bus.out_valid     = r_valid;
  assign bus.alu_result    = r_result;
  assign bus.store_data    = r_store;
  assign bus.out_dest_reg  = r_dest;
  assign bus.out_reg_write = r_reg_write;
  assign bus.out_mem_read  = r_mem_read;
  assign bus.out_mem_write = r_mem_write;
  assign bus.zero          = r_zero;
  assign bus.overflow      = r_overflow;
  assign bus.illegal_op    = r_illegal;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed, table-driven bench for ex_alu_stage plus stall/flush/reset sequences.
module tb_ex_alu_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ex_alu_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

  ex_alu_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          v;
    logic [3:0]    op;
    logic [DW-1:0] rs, rt, imm;
    logic          src;
    logic [1:0]    fa, fb;
    logic [DW-1:0] exf, wbf;
    logic [AW-1:0] dest;
    logic          rw, mr, mw;
    logic          e_valid;
    logic [DW-1:0] e_res, e_sd;
    logic          e_z, e_ovf, e_ill, e_rw, e_mr, e_mw;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.in_valid  = t.v;    bus.operation = t.op;
    bus.rs_data   = t.rs;   bus.rt_data   = t.rt;   bus.imm = t.imm;
    bus.alu_src   = t.src;  bus.fwd_a     = t.fa;   bus.fwd_b = t.fb;
    bus.exmem_fwd = t.exf;  bus.memwb_fwd = t.wbf;  bus.dest_reg = t.dest;
    bus.reg_write = t.rw;   bus.mem_read  = t.mr;   bus.mem_write = t.mw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag, input vec_t t);
    chk({tag, ".out_valid"},     DW'(bus.out_valid),     DW'(t.e_valid));
    chk({tag, ".alu_result"},    bus.alu_result,         t.e_res);
    chk({tag, ".store_data"},    bus.store_data,         t.e_sd);
    chk({tag, ".out_dest_reg"},  DW'(bus.out_dest_reg),  DW'(t.dest));
    chk({tag, ".zero"},          DW'(bus.zero),          DW'(t.e_z));
    chk({tag, ".overflow"},      DW'(bus.overflow),      DW'(t.e_ovf));
    chk({tag, ".illegal_op"},    DW'(bus.illegal_op),    DW'(t.e_ill));
    chk({tag, ".out_reg_write"}, DW'(bus.out_reg_write), DW'(t.e_rw));
    chk({tag, ".out_mem_read"},  DW'(bus.out_mem_read),  DW'(t.e_mr));
    chk({tag, ".out_mem_write"}, DW'(bus.out_mem_write), DW'(t.e_mw));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out_valid"},     DW'(bus.out_valid),     '0);
    chk({tag, ".alu_result"},    bus.alu_result,         '0);
    chk({tag, ".store_data"},    bus.store_data,         '0);
    chk({tag, ".out_dest_reg"},  DW'(bus.out_dest_reg),  '0);
    chk({tag, ".zero"},          DW'(bus.zero),          '0);
    chk({tag, ".overflow"},      DW'(bus.overflow),      '0);
    chk({tag, ".illegal_op"},    DW'(bus.illegal_op),    '0);
    chk({tag, ".out_reg_write"}, DW'(bus.out_reg_write), '0);
    chk({tag, ".out_mem_read"},  DW'(bus.out_mem_read),  '0);
    chk({tag, ".out_mem_write"}, DW'(bus.out_mem_write), '0);
  endtask

  initial begin
    //         v  op    rs            rt            imm           src fa fb exf    wbf    dst rw mr mw | val res           sd            z ovf ill rw mr mw
    vecs[0]  = '{1, 4'h4, 32'd5,        32'd7,        32'd0,        0, 0, 0, 32'h0,  32'h0,  3, 1, 0, 0,  1, 32'd12,       32'd7,        0, 0, 0, 1, 0, 0};
    vecs[1]  = '{1, 4'h3, 32'd0,        32'd0,        32'd0,        0, 1, 2, 32'hF0, 32'h0F, 4, 1, 0, 0,  1, 32'hFF,       32'h0F,       0, 0, 0, 1, 0, 0};
    vecs[2]  = '{1, 4'h7, 32'd0,        32'd0,        32'hFFFFFFFF, 1, 1, 2, 32'hF0, 32'h0F, 5, 1, 0, 0,  1, 32'hF0,       32'h0F,       0, 0, 0, 1, 0, 0};
    vecs[3]  = '{1, 4'h4, 32'h7FFFFFFF, 32'd1,        32'd0,        0, 0, 0, 32'h0,  32'h0,  6, 1, 0, 0,  1, 32'h80000000, 32'd1,        0, 1, 0, 1, 0, 0};
    vecs[4]  = '{1, 4'h5, 32'h80000000, 32'd1,        32'd0,        0, 0, 0, 32'h0,  32'h0,  7, 1, 0, 0,  1, 32'h7FFFFFFF, 32'd1,        0, 1, 0, 1, 0, 0};
    vecs[5]  = '{1, 4'h5, 32'd9,        32'd9,        32'd0,        0, 0, 0, 32'h0,  32'h0,  8, 1, 0, 0,  1, 32'd0,        32'd9,        1, 0, 0, 1, 0, 0};
    vecs[6]  = '{1, 4'h4, 32'hFFFFFFFF, 32'd1,        32'd0,        0, 3, 3, 32'h55, 32'h66, 9, 1, 1, 0,  1, 32'd0,        32'd1,        1, 0, 0, 1, 1, 0};
    vecs[7]  = '{1, 4'h4, 32'h80000000, 32'h80000000, 32'd0,        0, 0, 0, 32'h0,  32'h0, 10, 1, 0, 0,  1, 32'd0,        32'h80000000, 1, 1, 0, 1, 0, 0};
    vecs[8]  = '{1, 4'h4, 32'd100,      32'hDEAD,     32'd8,        1, 3, 0, 32'h0,  32'h0, 11, 0, 0, 1,  1, 32'd108,      32'hDEAD,     0, 0, 0, 0, 0, 1};
    vecs[9]  = '{0, 4'h4, 32'd1,        32'd1,        32'd0,        0, 0, 0, 32'h0,  32'h0, 12, 1, 1, 1,  0, 32'd2,        32'd1,        0, 0, 0, 0, 0, 0};
    vecs[10] = '{1, 4'hA, 32'd5,        32'd5,        32'd0,        0, 0, 0, 32'h0,  32'h0, 13, 1, 0, 0,  1, 32'd0,        32'd5,        1, 0, 1, 1, 0, 0};
    vecs[11] = '{0, 4'hA, 32'd5,        32'd5,        32'd0,        0, 0, 0, 32'h0,  32'h0, 14, 1, 0, 0,  0, 32'd0,        32'd5,        1, 0, 0, 0, 0, 0};
    vecs[12] = '{1, 4'h0, 32'd5,        32'd6,        32'd0,        0, 0, 0, 32'h0,  32'h0, 15, 1, 0, 0,  1, 32'd0,        32'd6,        1, 0, 0, 1, 0, 0};
    vecs[13] = '{1, 4'h5, 32'd3,        32'd5,        32'd0,        0, 0, 0, 32'h0,  32'h0, 16, 1, 0, 0,  1, 32'hFFFFFFFE, 32'd5,        0, 0, 0, 1, 0, 0};
    vecs[14] = '{0, 4'h4, 32'h7FFFFFFF, 32'd1,        32'd0,        0, 0, 0, 32'h0,  32'h0, 17, 1, 0, 0,  0, 32'h80000000, 32'd1,        0, 0, 0, 0, 0, 0};

    // Reset held with random inputs
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid  = 1'b1;
    bus.operation = 4'($urandom_range(0, 15));
    bus.rs_data   = $urandom;  bus.rt_data   = $urandom;  bus.imm = $urandom;
    bus.alu_src   = 1'($urandom); bus.fwd_a = 2'($urandom); bus.fwd_b = 2'($urandom);
    bus.exmem_fwd = $urandom;  bus.memwb_fwd = $urandom;
    bus.dest_reg  = 5'($urandom);
    bus.reg_write = 1'b1; bus.mem_read = 1'b1; bus.mem_write = 1'b1;
    step();
    step();
    chk_all_zero("reset");
    $display("reset held: out_valid=%0d alu_result=%h", bus.out_valid, bus.alu_result);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      step();
      $display("vec %0d: op=%h res=%h sd=%h z=%0d ovf=%0d ill=%0d valid=%0d",
               i, vecs[i].op, bus.alu_result, bus.store_data, bus.zero,
               bus.overflow, bus.illegal_op, bus.out_valid);
      chk_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Load 12, then stall three cycles with different inputs
    drive(vecs[0]);
    step();
    chk_vec("stall_load", vecs[0]);
    bus.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(vecs[3 + c]);
      step();
      $display("stall cycle %0d: res=%h valid=%0d", c, bus.alu_result, bus.out_valid);
      chk_vec($sformatf("stall%0d", c), vecs[0]);
    end

    // Stall and flush together: flush clears controls, datapath held
    drive(vecs[8]);
    bus.flush = 1'b1;
    step();
    $display("stall+flush: valid=%0d rw=%0d mw=%0d res=%h",
             bus.out_valid, bus.out_reg_write, bus.out_mem_write, bus.alu_result);
    chk("stflush.out_valid",     DW'(bus.out_valid),     '0);
    chk("stflush.out_reg_write", DW'(bus.out_reg_write), '0);
    chk("stflush.out_mem_write", DW'(bus.out_mem_write), '0);
    chk("stflush.alu_result",    bus.alu_result,         32'd12);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Async reset between edges during a stall
    drive(vecs[3]);
    step();
    chk_vec("pre_async", vecs[3]);
    bus.stall = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-stall: valid=%0d res=%h ovf=%0d",
             bus.out_valid, bus.alu_result, bus.overflow);
    chk_all_zero("async_rst");
    #2;
    rst_n = 1'b1;
    bus.stall = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
